jtag_scheduler: RTL

Shares one JTAG shift engine (op/work/busy control interface, instruction and data FIFOs) among NUM_REQ requesters. Round-robin arbitration; per-grant FIFO sufficiency check; one-cycle work strobe with op held stable; busy tracked through to completion; done/err returned to the owner. Sits between host command decoders and the JTAG engine.

---
 rtl/jtag_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/jtag_scheduler.sv
// Round-robin scheduler sharing one JTAG shift engine among NUM_REQ requesters.
// Optional engine busy timeout: define JTAG_SCHED_TIMEOUT_EN.
module jtag_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int WORDS_PER_DR   = 4,
  parameter int LVL_W          = 5,
  parameter int START_WAIT     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               jtag_op,
  output logic               jtag_work,
  input  logic               jtag_busy,
  input  logic               empty_instruction,
  input  logic [LVL_W-1:0]   data_level,
  output logic [15:0]        txn_count,
  output logic [7:0]         err_count
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    ST_RST_WAIT, ST_IDLE, ST_CHECK, ST_START,
    ST_WAIT_HI, ST_WAIT_LO, ST_DONE, ST_ERR
  } state_t;

  state_t state, state_nx;
  logic [IW-1:0]      idx, ptr, pick;
  logic               found, op_q, check_ok, start_tmo, tmo, to_rst;
  logic [15:0]        wcnt;
  logic [NUM_REQ-1:0] own;

  always_comb begin
    int unsigned j;
    j     = 0;
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  assign check_ok  = op_q ? (32'(data_level) >= 32'(WORDS_PER_DR)) : !empty_instruction;
  // The strobe cycle itself counts as the first cycle without busy.
  assign start_tmo = (32'(wcnt) + 32'd2) >= 32'(START_WAIT);

`ifdef JTAG_SCHED_TIMEOUT_EN
  logic [31:0] tcnt;
  assign tmo = jtag_busy && ((tcnt + 32'd1) >= 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt   <= '0;
      to_rst <= 1'b0;
    end else begin
      tcnt <= (state == ST_WAIT_LO && jtag_busy) ? tcnt + 32'd1 : '0;
      if (state == ST_WAIT_LO && tmo) to_rst <= 1'b1;
      else if (state == ST_ERR)       to_rst <= 1'b0;
    end
  end
`else
  assign tmo    = 1'b0;
  assign to_rst = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_RST_WAIT: if (!jtag_busy) state_nx = ST_IDLE;
      ST_IDLE:     if (found && !jtag_busy) state_nx = ST_CHECK;
      ST_CHECK:    state_nx = check_ok ? ST_START : ST_ERR;
      ST_START:    state_nx = ST_WAIT_HI;
      ST_WAIT_HI:  if (jtag_busy) state_nx = ST_WAIT_LO;
                   else if (start_tmo) state_nx = ST_ERR;
      ST_WAIT_LO:  if (!jtag_busy) state_nx = ST_DONE;
                   else if (tmo) state_nx = ST_ERR;
      ST_DONE:     state_nx = ST_IDLE;
      ST_ERR:      state_nx = to_rst ? ST_RST_WAIT : ST_IDLE;
      default:     state_nx = ST_RST_WAIT;
    endcase
  end

  always_comb begin
    own       = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    gnt       = '0;
    done      = '0;
    err       = '0;
    jtag_work = (state == ST_START);
    jtag_op   = 1'b0;
    if (state inside {ST_CHECK, ST_START, ST_WAIT_HI, ST_WAIT_LO, ST_DONE, ST_ERR})
      gnt = own;
    if (state inside {ST_START, ST_WAIT_HI, ST_WAIT_LO, ST_DONE, ST_ERR})
      jtag_op = op_q;
    if (state == ST_DONE) done = own;
    if (state == ST_ERR)  err  = own;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RST_WAIT;
      idx       <= '0;
      op_q      <= 1'b0;
      ptr       <= '0;
      wcnt      <= '0;
      txn_count <= '0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && found && !jtag_busy) begin
        idx  <= pick;
        op_q <= req_op[pick];
        ptr  <= IW'((32'(pick) + 32'd1) % NUM_REQ);
      end
      wcnt <= (state == ST_WAIT_HI) ? wcnt + 16'd1 : '0;
      if (state == ST_DONE) txn_count <= txn_count + 16'd1;
      if (state == ST_ERR && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule
